scan_car_controller: RTL and testbench

SCAN_CAR_CONTROLLER -- requirements
Module: scan_car_controller

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/scan_car.sv | 216 +++++++++++++++++++++
 rtl/scan_car_controller.sv | 50 +++++
 tb/tb_scan_car_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and constants for the SCAN elevator controller.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Per-car operating state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAVEL = 2'd1,
        DWELL  = 2'd2
    } car_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/scan_car.sv
`default_nettype none
// ============================================================================
// Module      : scan_car
// Description : One elevator car. Latches floor requests, runs a SCAN
//               (elevator-algorithm) FSM over half-floor positions and
//               pulses 'served' when a request is cleared at a stop.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_car
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS   = 6,
    parameter  int TRAVEL_TICKS = 60,
    parameter  int DWELL_TICKS  = 5,
    localparam int POS_W        = $clog2(2*NUM_FLOORS-1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] dest_req,
    input  logic [NUM_FLOORS-1:0] hall_req,
    output logic [POS_W-1:0]      half_pos,
    output logic                  dir,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] served
);

    localparam int c_tmr_max = (TRAVEL_TICKS > DWELL_TICKS) ? TRAVEL_TICKS : DWELL_TICKS;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
    localparam int c_flr_w   = POS_W - 1;

    localparam logic [POS_W-1:0]   c_pos_max     = POS_W'(2*NUM_FLOORS-2);
    localparam logic [c_tmr_w-1:0] c_travel_last = c_tmr_w'(TRAVEL_TICKS-1);
    localparam logic [c_tmr_w-1:0] c_dwell_last  = c_tmr_w'(DWELL_TICKS-1);

    // Returns {above, here, below}: pending requests relative to floor fl
    function automatic logic [2:0] scan_floor(input logic [NUM_FLOORS-1:0] p,
                                              input logic [c_flr_w-1:0]    fl);
        logic a;
        logic h;
        logic b;
        a = 1'b0;
        h = 1'b0;
        b = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (p[f]) begin
                if (f > int'(fl))       a = 1'b1;
                else if (f == int'(fl)) h = 1'b1;
                else                    b = 1'b1;
            end
        end
        return {a, h, b};
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_hot(input logic [c_flr_w-1:0] fl);
        logic [NUM_FLOORS-1:0] v;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            v[f] = (f == int'(fl));
        end
        return v;
    endfunction

    // Head toward the only side with work; with work on both sides keep going
    function automatic logic pick_dir(input logic [2:0] s, input logic cur);
        if (s[2] && !s[0]) return DIR_UP;
        if (s[0] && !s[2]) return DIR_DOWN;
        return cur;
    endfunction

    car_state_t            r_state_q,   w_state_d;
    logic [POS_W-1:0]      r_pos_q,     w_pos_d;
    logic                  r_dir_q,     w_dir_d;
    logic [c_tmr_w-1:0]    r_tmr_q,     w_tmr_d;
    logic [NUM_FLOORS-1:0] r_pending_q, w_pending_d;
    logic [NUM_FLOORS-1:0] r_served_q,  w_served_d;
    logic                  r_moving_q,  w_moving_d;
    logic                  r_door_q,    w_door_d;

    logic [NUM_FLOORS-1:0] w_req;
    logic [NUM_FLOORS-1:0] w_clr_entry;
    logic [NUM_FLOORS-1:0] w_clr_redo;
    logic [POS_W-1:0]      w_step_pos;
    logic [c_flr_w-1:0]    w_cur_fl;
    logic [c_flr_w-1:0]    w_nxt_fl;
    logic [2:0]            w_cur_scan;
    logic [2:0]            w_nxt_scan;
    logic                  w_any;
    logic                  w_at_end;
    logic                  w_ahead;
    logic                  w_behind;

    assign w_req      = dest_req | hall_req;
    assign w_step_pos = r_dir_q ? (r_pos_q + POS_W'(1)) : (r_pos_q - POS_W'(1));
    assign w_cur_fl   = r_pos_q[POS_W-1:1];
    assign w_nxt_fl   = w_step_pos[POS_W-1:1];
    assign w_cur_scan = scan_floor(r_pending_q, w_cur_fl);
    assign w_nxt_scan = scan_floor(r_pending_q, w_nxt_fl);
    assign w_any      = |r_pending_q;
    assign w_at_end   = r_dir_q ? (r_pos_q == c_pos_max) : (r_pos_q == '0);
    assign w_ahead    = r_dir_q ? w_nxt_scan[2] : w_nxt_scan[0];
    assign w_behind   = r_dir_q ? w_nxt_scan[0] : w_nxt_scan[2];

    // Next-state, position, timer and request bookkeeping
    always_comb begin
        w_state_d   = r_state_q;
        w_pos_d     = r_pos_q;
        w_dir_d     = r_dir_q;
        w_tmr_d     = r_tmr_q;
        w_clr_entry = '0;
        w_clr_redo  = '0;

        case (r_state_q)
            IDLE: begin
                if (w_any) begin
                    w_tmr_d = '0;
                    if (w_cur_scan[1]) begin
                        w_state_d   = DWELL;
                        w_clr_entry = floor_hot(w_cur_fl);
                    end else begin
                        w_state_d = TRAVEL;
                        w_dir_d   = pick_dir(w_cur_scan, r_dir_q);
                    end
                end
            end

            TRAVEL: begin
                if (tick) begin
                    if (r_tmr_q == c_travel_last) begin
                        w_tmr_d = '0;
                        if (w_at_end) begin
                            // Never step off the shaft; turn around instead
                            w_dir_d = ~r_dir_q;
                        end else begin
                            w_pos_d = w_step_pos;
                            // Decisions are only taken on arrival at a whole floor
                            if (!w_step_pos[0]) begin
                                if (w_nxt_scan[1]) begin
                                    w_state_d   = DWELL;
                                    w_clr_entry = floor_hot(w_nxt_fl);
                                end else if (!w_ahead) begin
                                    if (w_behind) w_dir_d   = ~r_dir_q;
                                    else          w_state_d = IDLE;
                                end
                            end
                        end
                    end else begin
                        w_tmr_d = r_tmr_q + c_tmr_w'(1);
                    end
                end
            end

            DWELL: begin
                if (w_cur_scan[1]) begin
                    // Fresh call for this floor: serve it and hold the doors
                    w_clr_redo = floor_hot(w_cur_fl);
                    w_tmr_d    = '0;
                end else if (tick) begin
                    if (r_tmr_q == c_dwell_last) begin
                        w_tmr_d = '0;
                        if (w_any) begin
                            w_state_d = TRAVEL;
                            w_dir_d   = pick_dir(w_cur_scan, r_dir_q);
                        end else begin
                            w_state_d = IDLE;
                        end
                    end else begin
                        w_tmr_d = r_tmr_q + c_tmr_w'(1);
                    end
                end
            end

            default: begin
                w_state_d = IDLE;
                w_tmr_d   = '0;
            end
        endcase

        // A request landing on the bit being cleared at arrival keeps it pending
        w_pending_d = (r_pending_q & ~(w_clr_entry | w_clr_redo)) | w_req;
        w_served_d  = (w_clr_entry & ~w_req) | w_clr_redo;
        w_moving_d  = (w_state_d == TRAVEL);
        w_door_d    = (w_state_d == DWELL);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_pos_q     <= '0;
            r_dir_q     <= DIR_UP;
            r_tmr_q     <= '0;
            r_pending_q <= '0;
            r_served_q  <= '0;
            r_moving_q  <= 1'b0;
            r_door_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pos_q     <= w_pos_d;
            r_dir_q     <= w_dir_d;
            r_tmr_q     <= w_tmr_d;
            r_pending_q <= w_pending_d;
            r_served_q  <= w_served_d;
            r_moving_q  <= w_moving_d;
            r_door_q    <= w_door_d;
        end
    end

    assign half_pos  = r_pos_q;
    assign dir       = r_dir_q;
    assign moving    = r_moving_q;
    assign door_open = r_door_q;
    assign served    = r_served_q;

endmodule
`default_nettype wire

// File: rtl/scan_car_controller.sv
`default_nettype none
// ============================================================================
// Module      : scan_car_controller
// Description : NUM_CARS independent SCAN elevator cars; this level only
//               slices the flat request/status buses per car.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_car_controller
    import elevator_pkg::*;
#(
    parameter  int NUM_CARS     = 2,
    parameter  int NUM_FLOORS   = 6,
    parameter  int TRAVEL_TICKS = 60,
    parameter  int DWELL_TICKS  = 5,
    localparam int POS_W        = $clog2(2*NUM_FLOORS-1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic [NUM_CARS*NUM_FLOORS-1:0] dest_req,
    input  logic [NUM_CARS*NUM_FLOORS-1:0] hall_req,
    output logic [NUM_CARS*POS_W-1:0]      half_pos,
    output logic [NUM_CARS-1:0]            dir,
    output logic [NUM_CARS-1:0]            moving,
    output logic [NUM_CARS-1:0]            door_open,
    output logic [NUM_CARS*NUM_FLOORS-1:0] served
);

    // One self-contained car per slice
    for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
        scan_car #(
            .NUM_FLOORS   (NUM_FLOORS),
            .TRAVEL_TICKS (TRAVEL_TICKS),
            .DWELL_TICKS  (DWELL_TICKS)
        ) u_car (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .dest_req  (dest_req[c*NUM_FLOORS +: NUM_FLOORS]),
            .hall_req  (hall_req[c*NUM_FLOORS +: NUM_FLOORS]),
            .half_pos  (half_pos[c*POS_W +: POS_W]),
            .dir       (dir[c]),
            .moving    (moving[c]),
            .door_open (door_open[c]),
            .served    (served[c*NUM_FLOORS +: NUM_FLOORS])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_car_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_car_controller
// Description : Self-checking bench: directed scenarios plus random traffic,
//               compared every cycle against a behavioural car model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_car_controller;

    localparam int NUM_CARS     = 2;
    localparam int NUM_FLOORS   = 6;
    localparam int TRAVEL_TICKS = 4;
    localparam int DWELL_TICKS  = 2;
    localparam int POS_W        = $clog2(2*NUM_FLOORS-1);
    localparam int NB           = NUM_CARS*NUM_FLOORS;
    localparam int TOP_POS      = 2*NUM_FLOORS-2;

    localparam int M_IDLE   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DWELL  = 2;

    logic                      clk      = 1'b0;
    logic                      rst      = 1'b1;
    logic                      tick     = 1'b1;
    logic [NB-1:0]             dest_req = '0;
    logic [NB-1:0]             hall_req = '0;
    logic [NUM_CARS*POS_W-1:0] half_pos;
    logic [NUM_CARS-1:0]       dir;
    logic [NUM_CARS-1:0]       moving;
    logic [NUM_CARS-1:0]       door_open;
    logic [NB-1:0]             served;

    int n_checks = 0;
    int n_errors = 0;
    int waited;
    int maxp;

    // Behavioural model: position, heading, activity and ticks left in the phase
    int m_pos  [NUM_CARS];
    int m_dir  [NUM_CARS];
    int m_mode [NUM_CARS];
    int m_left [NUM_CARS];
    bit m_pend [NUM_CARS][NUM_FLOORS];
    bit m_srv  [NUM_CARS][NUM_FLOORS];

    always #5 clk = ~clk;

    scan_car_controller #(
        .NUM_CARS     (NUM_CARS),
        .NUM_FLOORS   (NUM_FLOORS),
        .TRAVEL_TICKS (TRAVEL_TICKS),
        .DWELL_TICKS  (DWELL_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .dest_req  (dest_req),
        .hall_req  (hall_req),
        .half_pos  (half_pos),
        .dir       (dir),
        .moving    (moving),
        .door_open (door_open),
        .served    (served)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pend_between(input int c, input int lo, input int hi);
        int n;
        n = 0;
        for (int f = lo; f <= hi; f++) begin
            if (f >= 0 && f < NUM_FLOORS && m_pend[c][f]) n++;
        end
        return n;
    endfunction

    function automatic int pick_dir(input int c, input int fl);
        bit up;
        bit dn;
        up = pend_between(c, fl+1, NUM_FLOORS-1) > 0;
        dn = pend_between(c, 0, fl-1) > 0;
        if (up && !dn) return 1;
        if (dn && !up) return 0;
        return m_dir[c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CARS; c++) begin
            m_pos[c]  = 0;
            m_dir[c]  = 1;
            m_mode[c] = M_IDLE;
            m_left[c] = 0;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                m_pend[c][f] = 1'b0;
                m_srv[c][f]  = 1'b0;
            end
        end
    endtask

    task automatic model_car(input int c);
        bit r [NUM_FLOORS];
        int fl;
        int nf;
        int entry;
        int redo;
        int ahead;
        int behind;
        fl    = m_pos[c] / 2;
        entry = -1;
        redo  = -1;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            r[f] = dest_req[c*NUM_FLOORS+f] | hall_req[c*NUM_FLOORS+f];
        end
        case (m_mode[c])
            M_IDLE: begin
                if (pend_between(c, 0, NUM_FLOORS-1) > 0) begin
                    if (m_pend[c][fl]) begin
                        m_mode[c] = M_DWELL;
                        m_left[c] = DWELL_TICKS;
                        entry     = fl;
                    end else begin
                        m_dir[c]  = pick_dir(c, fl);
                        m_mode[c] = M_TRAVEL;
                        m_left[c] = TRAVEL_TICKS;
                    end
                end
            end
            M_TRAVEL: begin
                if (tick) begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        m_left[c] = TRAVEL_TICKS;
                        m_pos[c]  = m_pos[c] + ((m_dir[c] == 1) ? 1 : -1);
                        if (m_pos[c] % 2 == 0) begin
                            nf     = m_pos[c] / 2;
                            ahead  = (m_dir[c] == 1) ? pend_between(c, nf+1, NUM_FLOORS-1)
                                                     : pend_between(c, 0, nf-1);
                            behind = (m_dir[c] == 1) ? pend_between(c, 0, nf-1)
                                                     : pend_between(c, nf+1, NUM_FLOORS-1);
                            if (m_pend[c][nf]) begin
                                m_mode[c] = M_DWELL;
                                m_left[c] = DWELL_TICKS;
                                entry     = nf;
                            end else if (ahead == 0) begin
                                if (behind > 0) m_dir[c]  = 1 - m_dir[c];
                                else            m_mode[c] = M_IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                if (m_pend[c][fl]) begin
                    redo      = fl;
                    m_left[c] = DWELL_TICKS;
                end else if (tick) begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        if (pend_between(c, 0, NUM_FLOORS-1) > 0) begin
                            m_dir[c]  = pick_dir(c, fl);
                            m_mode[c] = M_TRAVEL;
                            m_left[c] = TRAVEL_TICKS;
                        end else begin
                            m_mode[c] = M_IDLE;
                        end
                    end
                end
            end
        endcase
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (f == entry) begin
                m_srv[c][f]  = !r[f];
                m_pend[c][f] = r[f];
            end else if (f == redo) begin
                m_srv[c][f]  = 1'b1;
                m_pend[c][f] = r[f];
            end else begin
                m_srv[c][f]  = 1'b0;
                m_pend[c][f] = m_pend[c][f] | r[f];
            end
        end
    endtask

    // Model advances on the same edge as the design
    always @(posedge clk) begin
        if (rst) model_reset();
        else for (int c = 0; c < NUM_CARS; c++) model_car(c);
    end

    task automatic compare_all();
        for (int c = 0; c < NUM_CARS; c++) begin
            logic [NUM_FLOORS-1:0] exp_srv;
            logic [POS_W-1:0]      hp;
            for (int f = 0; f < NUM_FLOORS; f++) exp_srv[f] = m_srv[c][f];
            hp = half_pos[c*POS_W +: POS_W];
            check($sformatf("car%0d half_pos", c),  32'(hp), m_pos[c]);
            check($sformatf("car%0d dir", c),       32'(dir[c]), m_dir[c]);
            check($sformatf("car%0d moving", c),    32'(moving[c]), 32'(m_mode[c] == M_TRAVEL));
            check($sformatf("car%0d door_open", c), 32'(door_open[c]), 32'(m_mode[c] == M_DWELL));
            check($sformatf("car%0d served", c),    32'(served[c*NUM_FLOORS +: NUM_FLOORS]), 32'(exp_srv));
            check($sformatf("car%0d in_shaft", c),  32'(hp <= POS_W'(TOP_POS)), 1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        check("reset half_pos", 32'(half_pos), 0);
        check("reset dir", 32'(dir), 3);
        check("reset moving/door", 32'({moving, door_open}), 0);

        // Car0 to floor 3 from reset
        dest_req[3] = 1'b1;
        cyc();
        dest_req[3] = 1'b0;
        cyc();
        check("f3 moving0", 32'(moving[0]), 1);
        repeat (24) cyc();
        check("f3 pos6", 32'(half_pos[POS_W-1:0]), 6);
        check("f3 door0", 32'(door_open[0]), 1);
        check("f3 served3", 32'(served[3]), 1);
        repeat (2) cyc();
        check("f3 door0 closed", 32'(door_open[0]), 0);
        check("f3 idle", 32'(moving[0]), 0);

        // Car1 hall call at its own floor, then a repeat call while dwelling
        hall_req[6] = 1'b1;
        cyc();
        hall_req[6] = 1'b0;
        cyc();
        check("c1 door", 32'(door_open[1]), 1);
        check("c1 served0", 32'(served[6]), 1);
        check("c1 pos", 32'(half_pos[POS_W +: POS_W]), 0);
        check("c0 unaffected", 32'(half_pos[POS_W-1:0]), 6);
        hall_req[6] = 1'b1;
        cyc();
        hall_req[6] = 1'b0;
        cyc();
        check("c1 second served", 32'(served[6]), 1);
        cyc();
        check("c1 door held", 32'(door_open[1]), 1);
        cyc();
        check("c1 door closed", 32'(door_open[1]), 0);

        // Car0 at floor 3 with work above and below: top end, then bottom
        dest_req[5] = 1'b1;
        hall_req[0] = 1'b1;
        cyc();
        dest_req[5] = 1'b0;
        hall_req[0] = 1'b0;
        maxp = 0;
        for (int i = 0; i < 120; i++) begin
            cyc();
            if (int'(half_pos[POS_W-1:0]) > maxp) maxp = int'(half_pos[POS_W-1:0]);
        end
        check("scan max pos", maxp, TOP_POS);
        check("scan end pos", 32'(half_pos[POS_W-1:0]), 0);
        check("scan end idle", 32'({moving[0], door_open[0]}), 0);

        // Reset in mid-travel discards the pending trip
        dest_req[5] = 1'b1;
        cyc();
        dest_req[5] = 1'b0;
        waited = 0;
        while (half_pos[POS_W-1:0] != POS_W'(3) && waited < 100) begin
            cyc();
            waited++;
        end
        check("reach pos3", 32'(waited < 100), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst pos", 32'(half_pos[POS_W-1:0]), 0);
        check("rst dir", 32'(dir[0]), 1);
        check("rst moving", 32'(moving[0]), 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("rst stays", 32'(moving[0]), 0);
        end

        // Tick gating mid-travel freezes the car
        dest_req[2] = 1'b1;
        cyc();
        dest_req[2] = 1'b0;
        repeat (5) cyc();
        check("pre-freeze pos", 32'(half_pos[POS_W-1:0]), 1);
        tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("frozen pos", 32'(half_pos[POS_W-1:0]), 1);
        end
        tick = 1'b1;
        repeat (4) cyc();
        check("resumed pos", 32'(half_pos[POS_W-1:0]), 2);
        repeat (30) cyc();

        // Random traffic with occasional resets and tick gaps
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 399) == 0);
            tick = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < NB; b++) begin
                dest_req[b] = ($urandom_range(0, 29) == 0);
                hall_req[b] = ($urandom_range(0, 29) == 0);
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
